asyn_controller: RTL and testbench

ASYN_CONTROLLER -- requirements
Module: asyn_controller

---
 rtl/asyn_ctrl_pkg.sv | 26 ++
 rtl/asyn_opcode_decode.sv | 52 +++++
 rtl/asyn_controller.sv | 98 +++++++++
 tb/tb_asyn_controller.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/asyn_ctrl_pkg.sv
// Shared opcode encodings and FSM state type for the stage-request sequencer.
// Opcodes are the RV32I major opcode field (inst[6:0]).
package asyn_ctrl_pkg;

    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_e;

endpackage

// File: rtl/asyn_opcode_decode.sv
// Pure combinational classification of a latched RV32I opcode.
// Zero latency; no flow control.
module asyn_opcode_decode
    import asyn_ctrl_pkg::*;
(
    input  logic [6:0] opc_i,
    output logic       legal_o,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       writes_rd_o
);

    always_comb begin
        legal_o     = 1'b0;
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        case (opc_i)
            OPC_LOAD: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; writes_rd_o = 1'b1;
            end
            OPC_STORE: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
            end
            OPC_OP_IMM: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; writes_rd_o = 1'b1;
            end
            OPC_OP: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; writes_rd_o = 1'b1;
            end
            OPC_BRANCH: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
            end
            OPC_JAL: begin
                legal_o = 1'b1; writes_rd_o = 1'b1;
            end
            OPC_JALR: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; writes_rd_o = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                legal_o = 1'b1; writes_rd_o = 1'b1;
            end
            OPC_SYSTEM: begin
                legal_o = 1'b1; uses_rs1_o = 1'b1; writes_rd_o = 1'b1;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/asyn_controller.sv
// Moore FSM issuing one-hot-per-stage requests (fetch/decode/exec/wb) for one instruction.
// Requests are registered from the next state; set is only honoured in IDLE.
module asyn_controller
    import asyn_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic [6:0] opcode,
    output logic       req1,
    output logic       req2_1,
    output logic       req2_2,
    output logic       req3,
    output logic       req4
);

    state_e     state_q, state_d;
    logic [6:0] opc_q, opc_d;
    logic       req1_q, req1_d;
    logic       req2_1_q, req2_1_d;
    logic       req2_2_q, req2_2_d;
    logic       req3_q, req3_d;
    logic       req4_q, req4_d;

    logic       legal, uses_rs1, uses_rs2, writes_rd;

    asyn_opcode_decode u_dec (
        .opc_i       (opc_q),
        .legal_o     (legal),
        .uses_rs1_o  (uses_rs1),
        .uses_rs2_o  (uses_rs2),
        .writes_rd_o (writes_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opc_q    <= '0;
            req1_q   <= 1'b0;
            req2_1_q <= 1'b0;
            req2_2_q <= 1'b0;
            req3_q   <= 1'b0;
            req4_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            req1_q   <= req1_d;
            req2_1_q <= req2_1_d;
            req2_2_q <= req2_2_d;
            req3_q   <= req3_d;
            req4_q   <= req4_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        req1_d   = 1'b0;
        req2_1_d = 1'b0;
        req2_2_d = 1'b0;
        req3_d   = 1'b0;
        req4_d   = 1'b0;

        // Decoder flags are valid in every non-IDLE state since opc_q was captured on entry to FETCH.
        case (state_q)
            ST_IDLE: begin
                if (set) begin
                    opc_d   = opcode;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH:  state_d = legal ? ST_DECODE : ST_IDLE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = writes_rd ? ST_WB : ST_IDLE;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs follow the state being entered so they appear registered alongside it.
        case (state_d)
            ST_FETCH:  req1_d = 1'b1;
            ST_DECODE: begin
                req2_1_d = uses_rs1;
                req2_2_d = uses_rs2;
            end
            ST_EXEC:   req3_d = 1'b1;
            ST_WB:     req4_d = 1'b1;
            default:   req1_d = 1'b0;
        endcase
    end

    assign req1   = req1_q;
    assign req2_1 = req2_1_q;
    assign req2_2 = req2_2_q;
    assign req3   = req3_q;
    assign req4   = req4_q;

endmodule

// File: tb/tb_asyn_controller.sv
// Directed bench for asyn_controller: per-cycle request patterns for several opcodes,
// held-set repetition, ignored set pulses and reset abort.
module tb_asyn_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       set;
    logic [6:0] opcode;
    logic       req1, req2_1, req2_2, req3, req4;

    int checks = 0;
    int errors = 0;

    asyn_controller dut (
        .clk    (clk),
        .reset  (reset),
        .set    (set),
        .opcode (opcode),
        .req1   (req1),
        .req2_1 (req2_1),
        .req2_2 (req2_2),
        .req3   (req3),
        .req4   (req4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp packs {req1, req2_1, req2_2, req3, req4}
    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {req1, req2_1, req2_2, req3, req4};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        set    = 1'b0;
        opcode = 7'b0000011;
        tick(); tick();
        check("reset_state", 5'b00000);

        // LOAD, set pulsed
        reset = 1'b0; set = 1'b1;
        tick(); check("load_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("load_decode", 5'b01000);
        tick(); check("load_exec", 5'b00010);
        tick(); check("load_wb", 5'b00001);
        tick(); check("load_idle", 5'b00000);

        // STORE: both reads, no write-back
        opcode = 7'b0100011; set = 1'b1;
        tick(); check("store_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("store_decode", 5'b01100);
        tick(); check("store_exec", 5'b00010);
        tick(); check("store_no_wb", 5'b00000);
        tick(); check("store_idle", 5'b00000);

        // LUI: empty decode cycle
        opcode = 7'b0110111; set = 1'b1;
        tick(); check("lui_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("lui_decode", 5'b00000);
        tick(); check("lui_exec", 5'b00010);
        tick(); check("lui_wb", 5'b00001);
        tick(); check("lui_idle", 5'b00000);

        // Illegal opcode: fetch only
        opcode = 7'b1111111; set = 1'b1;
        tick(); check("ill_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("ill_idle", 5'b00000);
        tick(); check("ill_idle2", 5'b00000);

        // BRANCH: two reads, no write-back
        opcode = 7'b1100011; set = 1'b1;
        tick(); check("br_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("br_decode", 5'b01100);
        tick(); check("br_exec", 5'b00010);
        tick(); check("br_no_wb", 5'b00000);

        // SYSTEM: rs1 only, writes rd
        opcode = 7'b1110011; set = 1'b1;
        tick(); check("sys_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("sys_decode", 5'b01000);
        tick(); check("sys_exec", 5'b00010);
        tick(); check("sys_wb", 5'b00001);
        tick(); check("sys_idle", 5'b00000);

        // set held with OP; opcode switched to STORE mid-sequence must not matter
        opcode = 7'b0110011; set = 1'b1;
        tick(); check("op1_fetch", 5'b10000);
        opcode = 7'b0100011;
        tick(); check("op1_decode", 5'b01100);
        tick(); check("op1_exec", 5'b00010);
        tick(); check("op1_wb", 5'b00001);
        opcode = 7'b0110011;
        tick(); check("op_gap", 5'b00000);
        tick(); check("op2_fetch", 5'b10000);
        tick(); check("op2_decode", 5'b01100);
        tick(); check("op2_exec", 5'b00010);
        tick(); check("op2_wb", 5'b00001);
        set = 1'b0;
        tick(); check("op2_idle", 5'b00000);

        // JAL with a set pulse during DECODE that must not be queued
        opcode = 7'b1101111; set = 1'b1;
        tick(); check("jal_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("jal_decode", 5'b00000);
        set = 1'b1; opcode = 7'b0000011;
        tick(); check("jal_exec", 5'b00010);
        set = 1'b0;
        tick(); check("jal_wb", 5'b00001);
        tick(); check("jal_idle", 5'b00000);
        tick(); check("jal_no_queue", 5'b00000);

        // Reset during EXEC aborts; no req4
        opcode = 7'b0110011; set = 1'b1;
        tick(); check("rst_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("rst_decode", 5'b01100);
        tick(); check("rst_exec", 5'b00010);
        reset = 1'b1;
        tick(); check("rst_abort", 5'b00000);
        reset = 1'b0;
        tick(); check("rst_no_wb", 5'b00000);

        // Reset has priority over set in the same cycle
        reset = 1'b1; set = 1'b1;
        tick(); check("rst_prio", 5'b00000);
        reset = 1'b0; set = 1'b0;
        tick(); check("rst_prio_idle", 5'b00000);

        // Opcode latched to 0 by reset is illegal; ordinary start afterwards still works
        opcode = 7'b0010011; set = 1'b1;
        tick(); check("opimm_fetch", 5'b10000);
        set = 1'b0;
        tick(); check("opimm_decode", 5'b01000);
        tick(); check("opimm_exec", 5'b00010);
        tick(); check("opimm_wb", 5'b00001);
        tick(); check("opimm_idle", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
